// File: rtl/amp_boot_seq.sv
// amp_boot_seq: boots an external amplifier over a write-only SPI link
// (mode 0, MSB first) using up to eight bytes captured from the register
// bank. A 0xFF byte ends the stream early and is never transmitted.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for a rising edge on amp_init_i
// S_CHECK    | one cycle: choose the next byte, or finish the sequence
// S_CS_SETUP | chip select asserted, waiting before the first clock
// S_BIT_LO   | sclk low, mosi presents the current bit
// S_BIT_HI   | sclk high, mosi held for the slave to sample
// S_CS_HOLD  | chip select held after the last bit, then released
module amp_boot_seq #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        amp_init_i,
  input  logic [63:0] bootmem_i,
  output logic        amp_sclk_o,
  output logic        amp_mosi_o,
  output logic        amp_csn_o,
  output logic [7:0]  status_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_CS_SETUP,
    S_BIT_LO,
    S_BIT_HI,
    S_CS_HOLD
  } state_t;

  // The final CHECK cycle is counted as part of the chip-select hold, so the
  // hold state itself runs one cycle short. With CLK_DIV=1 that leaves no
  // hold state at all and CHECK releases chip select directly.
  localparam logic [7:0] DIV_LD     = 8'(CLK_DIV - 1);
  localparam int         HOLD_N     = (CLK_DIV > 1) ? (CLK_DIV - 2) : 0;
  localparam logic [7:0] HOLD_LD    = 8'(HOLD_N);
  localparam bit         SHORT_HOLD = (CLK_DIV == 1);

  state_t      state_q;
  logic [7:0]  div_q;
  logic [2:0]  bit_q;
  logic [3:0]  count_q;
  logic [63:0] snap_q;
  logic        init_q;
  logic        armed_q;
  logic        busy_q;
  logic        done_q;
  logic        term_q;
  logic        sclk_q;
  logic        mosi_q;
  logic        csn_q;

  logic        start_d;
  logic [7:0]  byte_d;
  logic        is_term_d;
  logic        to_hold_d;

  // Edge detect on the boot request and selection of the active byte.
  // armed_q blocks a request that is already high when reset releases.
  always_comb begin
    start_d   = amp_init_i & ~init_q & armed_q;
    byte_d    = snap_q[{~count_q[2:0], 3'b000} +: 8];
    is_term_d = (count_q != 4'd8) && (byte_d == 8'hFF);
    to_hold_d = (count_q == 4'd8) || (is_term_d && (count_q != 4'd0));
  end

  // Sequencer with registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      div_q   <= 8'd0;
      bit_q   <= 3'd0;
      count_q <= 4'd0;
      snap_q  <= 64'd0;
      init_q  <= 1'b0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      term_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csn_q   <= 1'b1;
    end else begin
      armed_q <= 1'b1;
      init_q  <= amp_init_i;
      unique case (state_q)
        S_IDLE: begin
          if (start_d) begin
            state_q <= S_CHECK;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            term_q  <= 1'b0;
            count_q <= 4'd0;
            snap_q  <= bootmem_i;
          end
        end
        S_CHECK: begin
          if (is_term_d) term_q <= 1'b1;
          if (to_hold_d) begin
            if (SHORT_HOLD) begin
              state_q <= S_IDLE;
              csn_q   <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_CS_HOLD;
              div_q   <= HOLD_LD;
            end
          end else if (is_term_d) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (count_q == 4'd0) begin
            state_q <= S_CS_SETUP;
            csn_q   <= 1'b0;
            div_q   <= DIV_LD;
          end else begin
            state_q <= S_BIT_LO;
            bit_q   <= 3'd7;
            mosi_q  <= byte_d[7];
            div_q   <= DIV_LD;
          end
        end
        S_CS_SETUP: begin
          if (div_q == 8'd0) begin
            state_q <= S_BIT_LO;
            bit_q   <= 3'd7;
            mosi_q  <= byte_d[7];
            div_q   <= DIV_LD;
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        S_BIT_LO: begin
          if (div_q == 8'd0) begin
            state_q <= S_BIT_HI;
            sclk_q  <= 1'b1;
            div_q   <= DIV_LD;
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        S_BIT_HI: begin
          if (div_q == 8'd0) begin
            sclk_q <= 1'b0;
            if (bit_q == 3'd0) begin
              count_q <= count_q + 4'd1;
              state_q <= S_CHECK;
            end else begin
              bit_q   <= bit_q - 3'd1;
              mosi_q  <= byte_d[bit_q - 3'd1];
              state_q <= S_BIT_LO;
              div_q   <= DIV_LD;
            end
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        S_CS_HOLD: begin
          if (div_q == 8'd0) begin
            state_q <= S_IDLE;
            csn_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign amp_sclk_o = sclk_q;
  assign amp_mosi_o = mosi_q;
  assign amp_csn_o  = csn_q;
  assign status_o   = {busy_q, done_q, term_q, 1'b0, count_q};

endmodule

// File: tb/tb_amp_boot_seq.sv
// Directed bench for amp_boot_seq at CLK_DIV=4.
module tb_amp_boot_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        amp_init;
  logic [63:0] bootmem;
  logic        sclk;
  logic        mosi;
  logic        csn;
  logic [7:0]  status;

  int n_cmp = 0;
  int n_bad = 0;

  // Bus monitor state, cleared between tests.
  int          csn_low;
  int          rises;
  int          gap;
  int          gap8;
  int          busy_gap;
  logic [63:0] rx;
  logic        sclk_prev;
  bit          seen_rise;

  always #5 clk = ~clk;

  amp_boot_seq #(.CLK_DIV(4)) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .amp_init_i (amp_init),
    .bootmem_i  (bootmem),
    .amp_sclk_o (sclk),
    .amp_mosi_o (mosi),
    .amp_csn_o  (csn),
    .status_o   (status)
  );

  // Observe the serial bus on the falling edge.
  always @(negedge clk) begin
    if (csn === 1'b0) begin
      csn_low++;
      if (status[7] !== 1'b1) busy_gap++;
    end
    gap++;
    if (sclk === 1'b1 && sclk_prev === 1'b0) begin
      rises++;
      rx = {rx[62:0], mosi};
      if (seen_rise && gap == 8) gap8++;
      seen_rise = 1'b1;
      gap = 0;
    end
    sclk_prev = sclk;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    csn_low   = 0;
    rises     = 0;
    gap       = 0;
    gap8      = 0;
    busy_gap  = 0;
    rx        = 64'd0;
    seen_rise = 1'b0;
    sclk_prev = sclk;
  endtask

  task automatic pulse_init();
    amp_init = 1'b1;
    tick();
    tick();
    amp_init = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (status[7] === 1'b0) break;
      tick();
    end
    check_val(tag, status[7], 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    amp_init = 1'b0;
    bootmem  = 64'd0;
    clr_mon();
    repeat (3) tick();
    check_val("rst_csn", csn, 1'b1);
    check_val("rst_sclk", sclk, 1'b0);
    check_val("rst_mosi", mosi, 1'b0);
    check_val("rst_status", status, 8'h00);

    // request already high at reset release must not start
    amp_init = 1'b1;
    tick();
    rst = 1'b0;
    clr_mon();
    repeat (20) tick();
    check_val("hi_at_release_status", status, 8'h00);
    check_val("hi_at_release_csn", csn_low, 0);
    amp_init = 1'b0;
    repeat (3) tick();

    // four bytes then terminator
    bootmem = 64'h40483508FFFFFFFF;
    clr_mon();
    pulse_init();
    wait_idle("t1_done");
    check_val("t1_rises", rises, 32);
    check_val("t1_bytes", rx, 64'h0000000040483508);
    check_val("t1_csn_low", csn_low, 267);
    check_val("t1_status", status, 8'h64);
    check_val("t1_gap8", gap8, 28);

    // eight bytes, no terminator
    bootmem = 64'h0102030405060708;
    clr_mon();
    pulse_init();
    wait_idle("t2_done");
    check_val("t2_rises", rises, 64);
    check_val("t2_bytes", rx, 64'h0102030405060708);
    check_val("t2_csn_low", csn_low, 527);
    check_val("t2_status", status, 8'h48);
    check_val("t2_busy_gap", busy_gap, 0);
    check_val("t2_gap8", gap8, 56);

    // immediate terminator
    bootmem = 64'hFF00000000000000;
    clr_mon();
    amp_init = 1'b1;
    tick();
    check_val("t3_status_1", status, 8'h80);
    tick();
    check_val("t3_status_2", status, 8'h60);
    amp_init = 1'b0;
    repeat (10) tick();
    check_val("t3_csn_low", csn_low, 0);
    check_val("t3_rises", rises, 0);

    // reset mid-transfer, then a full rerun
    bootmem = 64'h0102030405060708;
    clr_mon();
    pulse_init();
    for (int i = 0; i < 2000; i++) begin
      if (rises >= 20) break;
      tick();
    end
    check_val("t4_rises_before_rst", rises, 20);
    #2;
    rst = 1'b1;
    #1;
    check_val("t4_rst_csn", csn, 1'b1);
    check_val("t4_rst_sclk", sclk, 1'b0);
    check_val("t4_rst_mosi", mosi, 1'b0);
    check_val("t4_rst_status", status, 8'h00);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    clr_mon();
    pulse_init();
    wait_idle("t4_done");
    check_val("t4_rises", rises, 64);
    check_val("t4_bytes", rx, 64'h0102030405060708);
    check_val("t4_status", status, 8'h48);

    // request toggles and bootmem rewrite during a transfer
    bootmem = 64'h40483508FFFFFFFF;
    clr_mon();
    pulse_init();
    repeat (30) tick();
    amp_init = 1'b1;
    bootmem  = 64'd0;
    tick();
    amp_init = 1'b0;
    tick();
    amp_init = 1'b1;
    tick();
    amp_init = 1'b0;
    wait_idle("t5_done");
    check_val("t5_bytes", rx, 64'h0000000040483508);
    check_val("t5_status", status, 8'h64);
    repeat (60) tick();
    check_val("t5_status_after", status, 8'h64);
    check_val("t5_rises", rises, 32);
    check_val("t5_csn_low", csn_low, 267);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
